// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit: operation and state
// encodings plus the {high, low} result layout at the default operand width.
package muldiv_params;

   localparam int MULDIV_DATA_WIDTH = 32;
   localparam int MULDIV_MUL_STAGES = 2;

   typedef enum logic {
      MULDIV_MUL,
      MULDIV_DIV
   } MuldivOperation;

   typedef enum logic [1:0] {
      MULDIV_IDLE,
      MULDIV_BUSY_MUL,
      MULDIV_BUSY_DIV,
      MULDIV_DONE
   } MuldivState;

   typedef struct packed {
      logic [MULDIV_DATA_WIDTH-1:0] high;
      logic [MULDIV_DATA_WIDTH-1:0] low;
   } MuldivResultData;

endpackage

// File: rtl/ex_muldiv_unit_divide_iterate_core.sv
// Restoring radix-2 divider on unsigned magnitudes. A start pulse loads the
// operands and iteration count; done is high whenever no iteration is pending.
module divide_iterate_core #(
   parameter int W  = 32,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [W-1:0]  dividend,
   input  logic [W-1:0]  divisor,
   input  logic [CW-1:0] iterations,
   output logic [W-1:0]  quotient,
   output logic [W-1:0]  remainder,
   output logic          done
);

   logic [W-1:0]  rem_q;
   logic [W-1:0]  quo_q;
   logic [W-1:0]  div_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    shifted;
   logic [W:0]    trial;
   logic [W-1:0]  rem_next;
   logic          quo_bit;

   // One iteration: shift the next dividend bit into the partial remainder and
   // keep the subtraction only when it does not go negative.
   always_comb begin
      shifted  = {rem_q, quo_q[W-1]};
      trial    = shifted - {1'b0, div_q};
      quo_bit  = ~trial[W];
      rem_next = quo_bit ? trial[W-1:0] : shifted[W-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         div_q <= divisor;
         cnt_q <= iterations;
      end else if (cnt_q != '0) begin
         rem_q <= rem_next;
         quo_q <= {quo_q[W-2:0], quo_bit};
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign done      = (cnt_q == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide engine with held {high, low} response.
// Define MULDIV_DIV_EARLY_EN to let the divider skip leading zeros of |dividend|.
module ex_muldiv_unit
   import muldiv_params::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  request_valid,
   output logic                  request_ready,
   input  MuldivOperation        request_op,
   input  logic                  request_signed,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic                  flush,
   output logic                  response_valid,
   input  logic                  response_ready,
   output logic [DATA_WIDTH-1:0] response_high,
   output logic [DATA_WIDTH-1:0] response_low,
   output logic                  busy,
   output MuldivState            debug_state
);

   // Handshakes: a request transfers on an edge where request_valid and
   // request_ready are both high; a response transfers on an edge where
   // response_valid and response_ready are both high and flush is low.
   localparam int W   = DATA_WIDTH;
   localparam int CW  = $clog2(W + 1);
   localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   typedef struct packed {
      logic [W-1:0] high;
      logic [W-1:0] low;
   } result_t;

   MuldivState     state_q;
   result_t        result_q;
   result_t        div_result;
   logic [2*W-1:0] mul_pipe_q [MUL_STAGES];
   logic [2*W-1:0] product;
   logic [MCW-1:0] mul_cnt_q;
   logic           accept;
   logic           start_div;
   logic           op1_neg;
   logic           op2_neg;
   logic [W-1:0]   op1_mag;
   logic [W-1:0]   op2_mag;
   logic [CW-1:0]  div_iters;
   logic [W-1:0]   div_dividend;
   logic           q_neg_q;
   logic           r_neg_q;
   logic           div_zero_q;
   logic           overflow_q;
   logic [W-1:0]   dividend_q;
   logic [W-1:0]   core_quotient;
   logic [W-1:0]   core_remainder;
   logic           core_done;

   assign request_ready = (state_q == MULDIV_IDLE) && !flush;
   assign accept        = request_valid && request_ready;
   assign start_div     = accept && (request_op == MULDIV_DIV);
   assign busy          = (state_q != MULDIV_IDLE);
   assign debug_state   = state_q;
   assign response_high = result_q.high;
   assign response_low  = result_q.low;

   // Sign-extending to 2W makes a single unsigned multiply give both products.
   always_comb begin
      op1_neg = request_signed & operand1[W-1];
      op2_neg = request_signed & operand2[W-1];
      op1_mag = op1_neg ? (~operand1 + W'(1)) : operand1;
      op2_mag = op2_neg ? (~operand2 + W'(1)) : operand2;
      product = {{W{op1_neg}}, operand1} * {{W{op2_neg}}, operand2};
   end

`ifdef MULDIV_DIV_EARLY_EN
   logic [CW-1:0] sig_bits;

   function automatic logic [CW-1:0] lead_zeros(input logic [W-1:0] v);
      lead_zeros = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (v[i]) lead_zeros = CW'(W - 1 - i);
      end
   endfunction

   // Pre-align the dividend so only its significant bits are iterated.
   always_comb begin
      sig_bits     = CW'(W) - lead_zeros(op1_mag);
      div_iters    = (operand2 == '0 || sig_bits == '0) ? CW'(1) : sig_bits;
      div_dividend = op1_mag << (CW'(W) - div_iters);
   end
`else
   assign div_iters    = CW'(W);
   assign div_dividend = op1_mag;
`endif

   divide_iterate_core #(
      .W  (W),
      .CW (CW)
   ) u_divide_core (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start_div),
      .dividend   (div_dividend),
      .divisor    (op2_mag),
      .iterations (div_iters),
      .quotient   (core_quotient),
      .remainder  (core_remainder),
      .done       (core_done)
   );

   // Sign correction; zero divisor and MIN/-1 override the magnitude result.
   always_comb begin
      div_result.low  = q_neg_q ? (~core_quotient + W'(1)) : core_quotient;
      div_result.high = r_neg_q ? (~core_remainder + W'(1)) : core_remainder;
      if (overflow_q) begin
         div_result.low  = MIN_VAL;
         div_result.high = '0;
      end
      if (div_zero_q) begin
         div_result.low  = '1;
         div_result.high = dividend_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MUL_STAGES; i++) mul_pipe_q[i] <= '0;
      end else begin
         if (accept && request_op == MULDIV_MUL) mul_pipe_q[0] <= product;
         for (int i = 1; i < MUL_STAGES; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= MULDIV_IDLE;
         response_valid <= 1'b0;
         result_q       <= '0;
         mul_cnt_q      <= '0;
         q_neg_q        <= 1'b0;
         r_neg_q        <= 1'b0;
         div_zero_q     <= 1'b0;
         overflow_q     <= 1'b0;
         dividend_q     <= '0;
      end else if (flush) begin
         state_q        <= MULDIV_IDLE;
         response_valid <= 1'b0;
         mul_cnt_q      <= '0;
      end else begin
         case (state_q)
            MULDIV_IDLE: begin
               if (accept) begin
                  mul_cnt_q  <= '0;
                  dividend_q <= operand1;
                  div_zero_q <= (operand2 == '0);
                  overflow_q <= request_signed && (operand1 == MIN_VAL) && (operand2 == '1);
                  q_neg_q    <= op1_neg ^ op2_neg;
                  r_neg_q    <= op1_neg;
                  state_q    <= (request_op == MULDIV_MUL) ? MULDIV_BUSY_MUL : MULDIV_BUSY_DIV;
               end
            end
            MULDIV_BUSY_MUL: begin
               if (mul_cnt_q == MCW'(MUL_STAGES - 1)) begin
                  result_q       <= mul_pipe_q[MUL_STAGES-1];
                  response_valid <= 1'b1;
                  state_q        <= MULDIV_DONE;
               end else begin
                  mul_cnt_q <= mul_cnt_q + MCW'(1);
               end
            end
            MULDIV_BUSY_DIV: begin
               if (core_done) begin
                  result_q       <= div_result;
                  response_valid <= 1'b1;
                  state_q        <= MULDIV_DONE;
               end
            end
            MULDIV_DONE: begin
               if (response_ready) begin
                  response_valid <= 1'b0;
                  state_q        <= MULDIV_IDLE;
               end
            end
            default: state_q <= MULDIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit (W=32, MUL_STAGES=2): arithmetic reference model,
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_ex_muldiv_unit;
   import muldiv_params::*;

   localparam int W = 32;

`ifdef MULDIV_DIV_EARLY_EN
   localparam int LAT_DIV_SMALL = 4;
`else
   localparam int LAT_DIV_SMALL = 33;
`endif

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic           request_valid = 1'b0;
   logic           request_ready;
   MuldivOperation request_op = MULDIV_MUL;
   logic           request_signed = 1'b0;
   logic [W-1:0]   operand1 = '0;
   logic [W-1:0]   operand2 = '0;
   logic           flush = 1'b0;
   logic           response_valid;
   logic           response_ready = 1'b0;
   logic [W-1:0]   response_high;
   logic [W-1:0]   response_low;
   logic           busy;
   MuldivState     debug_state;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit #(.DATA_WIDTH(W), .MUL_STAGES(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .request_valid  (request_valid),
      .request_ready  (request_ready),
      .request_op     (request_op),
      .request_signed (request_signed),
      .operand1       (operand1),
      .operand2       (operand2),
      .flush          (flush),
      .response_valid (response_valid),
      .response_ready (response_ready),
      .response_high  (response_high),
      .response_low   (response_low),
      .busy           (busy),
      .debug_state    (debug_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_result(input MuldivOperation op, input logic sgn,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      logic [W-1:0] q, r;
      if (op == MULDIV_MUL) begin
         if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
         end
         return {32'b0, a} * {32'b0, b};
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic int ref_latency(input MuldivOperation op, input logic sgn,
                                      input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_DIV_EARLY_EN
      logic [W-1:0] mag;
      int n;
`endif
      if (op == MULDIV_MUL) return 2;
`ifdef MULDIV_DIV_EARLY_EN
      if (b == 0) return 2;
      mag = (sgn && a[W-1]) ? -a : a;
      n = 0;
      while (mag != 0) begin
         n++;
         mag = mag >> 1;
      end
      if (n == 0) n = 1;
      return n + 1;
`else
      if (sgn || b != 0 || a != 0) return 33;
      return 33;
`endif
   endfunction

   logic        m_busy = 1'b0;
   logic        m_valid = 1'b0;
   int          m_count = 0;
   logic [63:0] m_result = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_count <= 0;
      end else if (flush) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
      end else if (m_valid) begin
         if (response_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
         end
      end else if (m_busy) begin
         m_count <= m_count - 1;
         if (m_count == 1) m_valid <= 1'b1;
      end else if (request_valid) begin
         m_busy   <= 1'b1;
         m_result <= ref_result(request_op, request_signed, operand1, operand2);
         m_count  <= ref_latency(request_op, request_signed, operand1, operand2);
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      check("resp_valid", 64'(response_valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(m_busy));
      check("req_ready", 64'(request_ready), 64'(!m_busy && !flush));
      if (m_valid) begin
         check("resp_high", 64'(response_high), 64'(m_result[63:32]));
         check("resp_low", 64'(response_low), 64'(m_result[31:0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_request(input MuldivOperation op, input logic sgn,
                             input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clock);
      #2;
      request_valid  = 1'b1;
      request_op     = op;
      request_signed = sgn;
      operand1       = a;
      operand2       = b;
      @(posedge clock);
      #2;
      request_valid  = 1'b0;
      request_op     = MuldivOperation'($urandom_range(0, 1));
      request_signed = 1'($urandom_range(0, 1));
      operand1       = $urandom;
      operand2       = $urandom;
   endtask

   task automatic wait_response(input string name, output int lat, output bit ok);
      ok  = 1'b0;
      lat = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         if (response_valid) begin
            lat = k;
            ok  = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_response required=response_valid", name);
      end
   endtask

   task automatic take_response();
      @(posedge clock);
      #2;
      response_ready = 1'b1;
      @(posedge clock);
      #2;
      response_ready = 1'b0;
   endtask

   task automatic run_directed(input string name, input MuldivOperation op, input logic sgn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                               input int exp_lat);
      int lat;
      bit ok;
      do_request(op, sgn, a, b);
      wait_response(name, lat, ok);
      if (ok) begin
         check({name, "_lat"}, 64'(lat), 64'(exp_lat));
         check({name, "_hi"}, 64'(response_high), 64'(exp_hi));
         check({name, "_lo"}, 64'(response_low), 64'(exp_lo));
      end
      take_response();
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] hold_hi, hold_lo;
      int lat;
      bit ok;

      // Model pinned to hand-computed values.
      check("model_umul", ref_result(MULDIV_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      check("model_smul", ref_result(MULDIV_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'h0000_0000_0000_0001);
      check("model_sdiv", ref_result(MULDIV_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      check("model_udiv", ref_result(MULDIV_DIV, 1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
      check("model_div0", ref_result(MULDIV_DIV, 1'b1, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);
      check("model_ovf", ref_result(MULDIV_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      // Reset state.
      @(negedge clock);
      check("rst_high", 64'(response_high), 64'h0);
      check("rst_low", 64'(response_low), 64'h0);
      check("rst_valid", 64'(response_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      check("rst_ready", 64'(request_ready), 64'h1);

      // MUL corners, DIV corners.
      run_directed("umul_max", MULDIV_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
      run_directed("smul_m1", MULDIV_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 2);
      run_directed("sdiv_m7_2", MULDIV_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                   LAT_DIV_SMALL);
      run_directed("udiv_100_7", MULDIV_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14,
                   ref_latency(MULDIV_DIV, 1'b0, 32'd100, 32'd7));
      run_directed("div_5_0", MULDIV_DIV, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF,
                   ref_latency(MULDIV_DIV, 1'b0, 32'd5, 32'd0));
      run_directed("sdiv_ovf", MULDIV_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
      run_directed("udiv_7_2", MULDIV_DIV, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3, LAT_DIV_SMALL);

      // Hold the response for 5 cycles, then back-to-back request.
      do_request(MULDIV_MUL, 1'b0, 32'd1234, 32'd5678);
      wait_response("hold", lat, ok);
      hold_hi = response_high;
      hold_lo = response_low;
      repeat (5) @(negedge clock);
      check("hold_hi", 64'(response_high), 64'(hold_hi));
      check("hold_lo", 64'(response_low), 64'(hold_lo));
      check("hold_req_ready", 64'(request_ready), 64'h0);
      check("hold_busy", 64'(busy), 64'h1);
      @(posedge clock);
      #2 response_ready = 1'b1;
      @(posedge clock);
      #2;
      response_ready = 1'b0;
      request_valid  = 1'b1;
      request_op     = MULDIV_MUL;
      request_signed = 1'b0;
      operand1       = 32'd3;
      operand2       = 32'd5;
      @(posedge clock);
      #2 request_valid = 1'b0;
      @(negedge clock);
      check("b2b_busy", 64'(busy), 64'h1);
      wait_response("b2b", lat, ok);
      if (ok) check("b2b_lo", 64'(response_low), 64'd15);
      take_response();

      // Flush during a divide with a competing request.
      do_request(MULDIV_DIV, 1'b0, 32'd1000, 32'd7);
      repeat (10) @(posedge clock);
      #2;
      flush          = 1'b1;
      request_valid  = 1'b1;
      request_op     = MULDIV_MUL;
      operand1       = 32'd9;
      operand2       = 32'd9;
      @(posedge clock);
      #2;
      flush         = 1'b0;
      request_valid = 1'b0;
      @(negedge clock);
      check("flush_busy", 64'(busy), 64'h0);
      check("flush_valid", 64'(response_valid), 64'h0);
      repeat (40) @(negedge clock);
      run_directed("mul_3_4", MULDIV_MUL, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 2);

      // Asynchronous reset mid-MUL.
      do_request(MULDIV_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      #1 reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(response_valid), 64'h0);
      check("arst_busy", 64'(busy), 64'h0);
      check("arst_low", 64'(response_low), 64'h0);
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      run_directed("mul_6_7", MULDIV_MUL, 1'b1, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 2);

      // Randomized traffic with random response stalls and flushes.
      for (int n = 0; n < 80; n++) begin
         MuldivOperation op;
         logic sgn;
         logic [W-1:0] a, b;
         op  = MuldivOperation'($urandom_range(0, 1));
         sgn = 1'($urandom_range(0, 1));
         a   = pick_operand();
         b   = pick_operand();
         do_request(op, sgn, a, b);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 40)) @(posedge clock);
            #2;
            flush          = 1'b1;
            response_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #2;
            flush          = 1'b0;
            response_ready = 1'b0;
         end else begin
            wait_response("rand", lat, ok);
            if (ok) check("rand_lat", 64'(lat), 64'(ref_latency(op, sgn, a, b)));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            take_response();
         end
      end

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
